// File: rtl/obi_rvalid_stall_fifo.sv
// In-order OBI response FIFO that holds each granted transfer and releases its rvalid after a per-transfer stall.
// Optional `define OBI_RVALID_STALL_ERR_EN adds err_i/err_o with per-entry error storage.
module obi_rvalid_stall_fifo #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DELAY_W   = 4,
    parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   gnt_i,
    input  logic                   we_i,
    output logic                   gnt_o,
    input  logic [DATA_W-1:0]      rdata_i,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   rvalid_o,
    input  logic                   en_stall_i,
    input  logic [1:0]             stall_mode_i,
    input  logic [DELAY_W-1:0]     max_stall_i,
    input  logic [DELAY_W-1:0]     valid_stall_i,
`ifdef OBI_RVALID_STALL_ERR_EN
    input  logic                   err_i,
    output logic                   err_o,
`endif
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned IDX_W       = $clog2(DEPTH);
    localparam int unsigned PTR_W       = IDX_W + 1;
    localparam logic [31:0] LFSR_TAPS   = 32'h80200003;
    localparam logic [1:0]  MODE_FIXED  = 2'd1;
    localparam logic [1:0]  MODE_RANDOM = 2'd2;

    function automatic logic [DELAY_W-1:0] clamp_delay(input logic [DELAY_W-1:0] d,
                                                       input logic [DELAY_W-1:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [31:0]        r_lfsr;
    logic               r_pend_vld;
    logic [IDX_W-1:0]   r_pend_idx;
    logic [DEPTH-1:0]   r_we;
    logic [DEPTH-1:0]   r_dvalid;
    logic [DELAY_W-1:0] r_delay [DEPTH];
    logic [DATA_W-1:0]  r_data  [DEPTH];
`ifdef OBI_RVALID_STALL_ERR_EN
    logic [DEPTH-1:0]   r_err;
`endif

    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_head_dec;
    logic               w_head_bypass;
    logic               w_head_avail;
    logic [DELAY_W-1:0] w_head_delay;
    logic [DELAY_W-1:0] w_new_delay;

    assign w_wr_idx = r_wptr[IDX_W-1:0];
    assign w_rd_idx = r_rptr[IDX_W-1:0];
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (w_wr_idx == w_rd_idx) && (r_wptr[IDX_W] != r_rptr[IDX_W]);
    assign level_o  = r_wptr - r_rptr;

    // Grant is held low through reset and whenever full, even if the head pops this cycle.
    assign gnt_o  = gnt_i & ~w_full & rst_ni;
    assign w_push = req_i & gnt_o;

    always_comb begin
        w_new_delay = '0;
        if (en_stall_i) begin
            case (stall_mode_i)
                MODE_FIXED:  w_new_delay = clamp_delay(valid_stall_i, max_stall_i);
                MODE_RANDOM: w_new_delay = clamp_delay(r_lfsr[DELAY_W-1:0], max_stall_i);
                default:     w_new_delay = '0;
            endcase
        end
    end

    // The head is only ever an entry pushed in an earlier cycle: emptiness comes from registers.
    assign w_head_delay  = r_delay[w_rd_idx];
    assign w_head_bypass = r_pend_vld && (r_pend_idx == w_rd_idx) && !r_dvalid[w_rd_idx];
    assign w_head_avail  = r_dvalid[w_rd_idx] | w_head_bypass;
    assign w_head_dec    = !w_empty && (w_head_delay != '0);
    assign w_pop         = !w_empty && (w_head_delay == '0) && w_head_avail;

    always_comb begin
        rvalid_o = w_pop;
        rdata_o  = '0;
        if (w_pop && !r_we[w_rd_idx]) begin
            rdata_o = w_head_bypass ? rdata_i : r_data[w_rd_idx];
        end
    end

`ifdef OBI_RVALID_STALL_ERR_EN
    always_comb begin
        err_o = 1'b0;
        if (w_pop && !r_we[w_rd_idx]) begin
            err_o = w_head_bypass ? err_i : r_err[w_rd_idx];
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_lfsr     <= LFSR_SEED;
            r_pend_vld <= 1'b0;
            r_pend_idx <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
                r_lfsr <= lfsr_next(r_lfsr);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // A read pushed now has its rdata_i one cycle later; remember where it goes.
            r_pend_vld <= w_push & ~we_i;
            r_pend_idx <= w_wr_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we     <= '0;
            r_dvalid <= '0;
`ifdef OBI_RVALID_STALL_ERR_EN
            r_err    <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                r_delay[i] <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (w_wr_idx == IDX_W'(i))) begin
                    r_we[i]     <= we_i;
                    r_dvalid[i] <= we_i;
                    r_delay[i]  <= w_new_delay;
                    r_data[i]   <= '0;
`ifdef OBI_RVALID_STALL_ERR_EN
                    r_err[i]    <= 1'b0;
`endif
                end else begin
                    // Data capture and head countdown may hit different slots in the same cycle.
                    if (r_pend_vld && (r_pend_idx == IDX_W'(i))) begin
                        r_data[i]   <= rdata_i;
                        r_dvalid[i] <= 1'b1;
`ifdef OBI_RVALID_STALL_ERR_EN
                        r_err[i]    <= err_i;
`endif
                    end
                    if (w_head_dec && (w_rd_idx == IDX_W'(i))) begin
                        r_delay[i] <= r_delay[i] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_obi_rvalid_stall_fifo.sv
// Directed bench for obi_rvalid_stall_fifo: vector table for single transfers, hand sequences for
// stall ordering, full back-pressure, reset flush and LFSR-random delays.
module tb_obi_rvalid_stall_fifo;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_i, gnt_i, we_i, en_stall_i;
    logic        gnt_o, rvalid_o;
    logic [31:0] rdata_i, rdata_o;
    logic [1:0]  stall_mode_i;
    logic [3:0]  max_stall_i, valid_stall_i;
    logic [3:0]  level_o;
`ifdef OBI_RVALID_STALL_ERR_EN
    logic        err_i, err_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    obi_rvalid_stall_fifo dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .gnt_i        (gnt_i),
        .we_i         (we_i),
        .gnt_o        (gnt_o),
        .rdata_i      (rdata_i),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .en_stall_i   (en_stall_i),
        .stall_mode_i (stall_mode_i),
        .max_stall_i  (max_stall_i),
        .valid_stall_i(valid_stall_i),
`ifdef OBI_RVALID_STALL_ERR_EN
        .err_i        (err_i),
        .err_o        (err_o),
`endif
        .level_o      (level_o)
    );

    typedef struct {
        logic        req, gnt, we, en;
        logic [1:0]  mode;
        logic [3:0]  mx, vs;
        logic [31:0] rd;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_gnt;
        logic [3:0]  e_lvl;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic req, gnt, we, en, input logic [1:0] mode,
                                input logic [3:0] mx, vs, input logic [31:0] rd,
                                input logic e_rv, input logic [31:0] e_rd,
                                input logic e_gnt, input logic [3:0] e_lvl);
        vec_t v;
        v.req = req; v.gnt = gnt; v.we = we; v.en = en; v.mode = mode;
        v.mx = mx; v.vs = vs; v.rd = rd;
        v.e_rv = e_rv; v.e_rd = e_rd; v.e_gnt = e_gnt; v.e_lvl = e_lvl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_i  = 1'b0;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    // One isolated transfer; returns cycles from push to rvalid (-1 if none within budget).
    task automatic xfer(input logic we, input logic [31:0] d, output int lat, output logic [31:0] got);
        lat = -1;
        got = '0;
        req_i = 1'b1; we_i = we; rdata_i = 32'h0;
        @(negedge clk);
        next_cycle();
        req_i = 1'b0;
        for (int t = 1; t <= 8 && lat < 0; t++) begin
            rdata_i = (t == 1) ? d : ~d;
            @(negedge clk);
            if (rvalid_o) begin
                lat = t;
                got = rdata_o;
            end
            next_cycle();
        end
    endtask

    logic        r_we_a [1000];
    logic [31:0] r_rd_a [1000];
    int          lat1   [1000];

    task automatic random_pass(input int pass);
        logic [31:0] lfsr;
        logic [31:0] got, exp_d;
        logic [3:0]  dly;
        int          lat;
        lfsr = 32'hACE12468;
        for (int i = 0; i < 1000; i++) begin
            dly  = (lfsr[3:0] > 4'd2) ? 4'd2 : lfsr[3:0];
            lfsr = lfsr[0] ? ((lfsr >> 1) ^ 32'h80200003) : (lfsr >> 1);
            exp_d = r_we_a[i] ? 32'h0 : r_rd_a[i];
            xfer(r_we_a[i], r_rd_a[i], lat, got);
            chk($sformatf("rand p%0d #%0d latency", pass, i), lat, 1 + dly);
            chk($sformatf("rand p%0d #%0d data", pass, i), got, exp_d);
            if (pass == 0) lat1[i] = lat;
            else chk($sformatf("rand repeat #%0d latency", i), lat, lat1[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d3 [3];
        int          nresp;

        rst_ni = 1'b0; req_i = 1'b1; gnt_i = 1'b1; we_i = 1'b0; en_stall_i = 1'b0;
        stall_mode_i = 2'd0; max_stall_i = 4'd15; valid_stall_i = 4'd0; rdata_i = 32'h0;
`ifdef OBI_RVALID_STALL_ERR_EN
        err_i = 1'b0;
`endif
        #3;
        chk("reset rvalid", rvalid_o, 0);
        chk("reset rdata", rdata_o, 0);
        chk("reset level", level_o, 0);
        chk("reset gnt_o", gnt_o, 0);
        do_reset();

        //            req gnt we en mode mx  vs  rdata         rv  rdata_o       gnt lvl
        vecs[0]  = mk(1, 1, 0, 0, 2'd1, 15, 5, 32'h0,        0, 32'h0,        1, 0);
        vecs[1]  = mk(0, 1, 0, 0, 2'd1, 15, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 1);
        vecs[2]  = mk(0, 1, 0, 1, 2'd1, 15, 3, 32'h0,        0, 32'h0,        1, 0);
        vecs[3]  = mk(1, 1, 1, 1, 2'd1, 15, 3, 32'h0,        0, 32'h0,        1, 0);
        vecs[4]  = mk(0, 1, 0, 1, 2'd1, 15, 3, 32'h11111111, 0, 32'h0,        1, 1);
        vecs[5]  = mk(0, 1, 0, 1, 2'd1, 15, 3, 32'h0,        0, 32'h0,        1, 1);
        vecs[6]  = mk(0, 1, 0, 1, 2'd1, 15, 3, 32'h0,        0, 32'h0,        1, 1);
        vecs[7]  = mk(0, 1, 0, 1, 2'd1, 15, 3, 32'h22222222, 1, 32'h0,        1, 1);
        vecs[8]  = mk(0, 1, 0, 1, 2'd1, 15, 3, 32'h0,        0, 32'h0,        1, 0);
        vecs[9]  = mk(1, 1, 0, 1, 2'd1,  1, 2, 32'h0,        0, 32'h0,        1, 0);
        vecs[10] = mk(0, 1, 0, 1, 2'd1,  1, 2, 32'hCAFEF00D, 0, 32'h0,        1, 1);
        vecs[11] = mk(0, 1, 0, 1, 2'd1,  1, 2, 32'h12345678, 1, 32'hCAFEF00D, 1, 1);
        vecs[12] = mk(0, 1, 0, 1, 2'd3, 15, 5, 32'h0,        0, 32'h0,        1, 0);
        vecs[13] = mk(1, 1, 0, 1, 2'd3, 15, 5, 32'h0,        0, 32'h0,        1, 0);
        vecs[14] = mk(0, 1, 0, 1, 2'd3, 15, 5, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1, 1);
        vecs[15] = mk(1, 0, 0, 1, 2'd0, 15, 0, 32'h0,        0, 32'h0,        0, 0);
        vecs[16] = mk(0, 1, 0, 1, 2'd0, 15, 0, 32'h77777777, 0, 32'h0,        1, 0);
        vecs[17] = mk(1, 1, 0, 1, 2'd0, 15, 0, 32'h0,        0, 32'h0,        1, 0);
        vecs[18] = mk(1, 1, 1, 1, 2'd0, 15, 0, 32'h0000AAAA, 1, 32'h0000AAAA, 1, 1);
        vecs[19] = mk(0, 1, 0, 1, 2'd0, 15, 0, 32'h0000BBBB, 1, 32'h0,        1, 1);
        vecs[20] = mk(0, 1, 0, 1, 2'd0, 15, 0, 32'h0,        0, 32'h0,        1, 0);

        for (int i = 0; i < NVEC; i++) begin
            req_i = vecs[i].req; gnt_i = vecs[i].gnt; we_i = vecs[i].we;
            en_stall_i = vecs[i].en; stall_mode_i = vecs[i].mode;
            max_stall_i = vecs[i].mx; valid_stall_i = vecs[i].vs; rdata_i = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d rvalid", i), rvalid_o, vecs[i].e_rv);
            chk($sformatf("vec%0d rdata", i), rdata_o, vecs[i].e_rd);
            chk($sformatf("vec%0d gnt_o", i), gnt_o, vecs[i].e_gnt);
            chk($sformatf("vec%0d level", i), level_o, vecs[i].e_lvl);
            next_cycle();
        end

        // Stalled head blocks younger reads: delay min(9,4)=4 each, served one after another.
        req_i = 1'b0; gnt_i = 1'b1; we_i = 1'b0; en_stall_i = 1'b1;
        stall_mode_i = 2'd1; valid_stall_i = 4'd9; max_stall_i = 4'd4;
        d3[0] = 32'h0BAD0001; d3[1] = 32'h0BAD0002; d3[2] = 32'h0BAD0003;
        nresp = 0;
        for (int c = 0; c < 22; c++) begin
            req_i   = (c < 3);
            rdata_i = (c >= 1 && c <= 3) ? d3[c-1] : 32'hF0F0F0F0;
            @(negedge clk);
            if (rvalid_o) begin
                if (nresp < 3) begin
                    chk($sformatf("order resp%0d cycle", nresp), c, 5 + 5 * nresp);
                    chk($sformatf("order resp%0d data", nresp), rdata_o, d3[nresp]);
                end
                nresp++;
            end
            next_cycle();
        end
        chk("order resp count", nresp, 3);

        // Full back-pressure with 15-cycle head stall.
        do_reset();
        we_i = 1'b1; gnt_i = 1'b1; stall_mode_i = 2'd1; valid_stall_i = 4'd15; max_stall_i = 4'd15;
        for (int c = 0; c < 18; c++) begin
            req_i = (c < 10);
            @(negedge clk);
            if (c < 10) chk($sformatf("full c%0d gnt_o", c), gnt_o, (c < 8));
            if (c == 9) chk("full level", level_o, 8);
            if (c >= 10 && c < 16) chk($sformatf("full c%0d rvalid", c), rvalid_o, 0);
            if (c == 16) begin
                chk("full first pop rvalid", rvalid_o, 1);
                chk("full gnt_o during pop", gnt_o, 0);
            end
            if (c == 17) begin
                chk("full gnt_o after pop", gnt_o, 1);
                chk("full level after pop", level_o, 7);
            end
            next_cycle();
        end

        // Asynchronous reset with five outstanding transfers.
        do_reset();
        we_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_i = (c < 5);
            @(negedge clk);
            next_cycle();
        end
        chk("rst pre level", level_o, 5);
        rst_ni = 1'b0;
        #1;
        chk("rst async rvalid", rvalid_o, 0);
        chk("rst async level", level_o, 0);
        chk("rst async gnt_o", gnt_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            chk($sformatf("rst stale c%0d rvalid", c), rvalid_o, 0);
            next_cycle();
        end
        chk("rst post level", level_o, 0);

`ifdef OBI_RVALID_STALL_ERR_EN
        do_reset();
        stall_mode_i = 2'd0; we_i = 1'b0; req_i = 1'b1; err_i = 1'b0;
        @(negedge clk);
        next_cycle();
        req_i = 1'b0; rdata_i = 32'h5; err_i = 1'b1;
        @(negedge clk);
        chk("err bypass rvalid", rvalid_o, 1);
        chk("err bypass err_o", err_o, 1);
        next_cycle();
        stall_mode_i = 2'd1; valid_stall_i = 4'd1; req_i = 1'b1; err_i = 1'b0;
        @(negedge clk);
        next_cycle();
        req_i = 1'b0; err_i = 1'b1;
        @(negedge clk);
        chk("err stored wait", rvalid_o, 0);
        next_cycle();
        err_i = 1'b0;
        @(negedge clk);
        chk("err stored rvalid", rvalid_o, 1);
        chk("err stored err_o", err_o, 1);
        next_cycle();
`endif

        // LFSR-random delays, two passes from reset with identical stimulus.
        for (int i = 0; i < 1000; i++) begin
            r_we_a[i] = 1'($urandom_range(0, 1));
            r_rd_a[i] = $urandom;
        end
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            en_stall_i = 1'b1; stall_mode_i = 2'd2; max_stall_i = 4'd2; gnt_i = 1'b1;
            random_pass(pass);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
